alu_exec: RTL and testbench
===========================

Name: alu_exec

Overview:
- Registered, handshaked ALU execute stage for core0; successor to the combinational ALU operand/opcode decode.
- Decodes an 8-bit instruction using the shared instruction-encoding macros (`I_*`) and selects operands.
- Holds the architectural carry flag in a register.
- Runs add/logic ops in one cycle and shifts iteratively over multiple cycles.
- Sits between the stack-top operand fetch and writeback; valid/ready on both sides.

Parameters:
- WORD_WIDTH, 32, data word width; power of 2, ≥ 8.
- DC_COUNT, 4, number of dc_vals channels; one of 1, 2, 4. Index = instruction[$clog2(DC_COUNT)-1:0], 0 when DC_COUNT = 1.
- SHIFT_STEP, 1, bit positions shifted per cycle in iterative shift mode; power of 2, ≤ WORD_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction/operands valid.
- in_ready  out  1  stage can accept.
- instruction  in  8  opcode byte.
- top  in  WORD_WIDTH  stack top; add operand b; shift amount source.
- second  in  WORD_WIDTH  second stack element; shift/logic data operand.
- dc_vals  in  DC_COUNT*WORD_WIDTH  constant channels for ADDZ.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  WORD_WIDTH  registered result.
- carry  out  1  current carry flag.
- illegal  out  1  one-cycle pulse on an unrecognised instruction.

Behaviour:
- Reset (async, reset_n = 0): state = IDLE; out_valid, carry, illegal = 0; result = 0; in_ready = 0 while in reset.
- States: IDLE, SHIFT, HOLD.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- Accept = in_valid && in_ready, sampled on a rising edge.
- Add class (ADDZ, INC, DEC, CARRY, BORROW, ADD, ADDC, SUB, SUBC):
  - {c, r} = a + top + ic, computed at WORD_WIDTH+1 bits.
  - a/ic per op: ADDZ → dc_vals[idx]/0; INC → 1/0; DEC → all-ones/0; CARRY → 0/carry; BORROW → all-ones/carry; ADD → second/0; ADDC → second/carry; SUB → ~second/1; SUBC → ~second/carry.
  - On accept: result ← r, carry ← c, out_valid ← 1. Latency 1.
  - The carry used is the flag value at the accept edge, so back-to-back accepts chain correctly.
- AND, OR: result ← second op top; carry unchanged; latency 1.
- Shifts (LSL, LSR, CSL, CSR, ASR):
  - Data = second; amount n = top[$clog2(WORD_WIDTH)-1:0].
  - n = 0: result ← second, latency 1.
  - n > 0: enter SHIFT; each cycle shift by min(SHIFT_STEP, remaining); out_valid after ceil(n/SHIFT_STEP) edges.
  - CSL/CSR rotate; ASR replicates the MSB; LSL/LSR fill with 0.
  - Carry unchanged.
  - in_ready = 0 during SHIFT.
- HOLD: out_valid = 1 && !out_ready. result and carry stay stable; no accept.
- Completion with out_ready = 1 and a new accept in the same cycle is legal (full throughput for 1-cycle ops).
- Unrecognised instruction:
  - Accepted.
  - illegal = 1 for one cycle.
  - No out_valid; result and carry unchanged.
- out_valid clears on the edge where out_valid && out_ready unless a new result completes on that same edge.
- Reset asserted mid-SHIFT or mid-HOLD: the operation is discarded and all state returns to reset values immediately.

Optional Feature:
- Macro: ALU_EXEC_BARREL_SHIFT_EN.
- Defined: shifts are single-cycle combinational barrel shifts. Latency is 1 for every n, the SHIFT state is unused, and SHIFT_STEP is ignored.
- Undefined: iterative SHIFT_STEP-per-cycle behaviour as above.

Test Plan:
- ADD, top=5, second=7 → out_valid 1 cycle after accept, result=12, carry=0.
- ADD, top=0xFFFFFFFF, second=1 → result=0, carry=1. Next ADDC, top=0, second=0 → result=1, carry=0.
- SUB, top=3, second=5 → result=0xFFFFFFFE, carry=0. SUB, top=5, second=3 → result=2, carry=1.
- LSL, second=1, top=5, SHIFT_STEP=1, macro off → in_ready low for 5 cycles, result=0x20 after 5 edges. Same stimulus with macro on → latency 1.
- ADD with out_ready held 0 for 3 cycles → result stable, in_ready=0. Release → transfer; a second ADD is accepted in the same cycle.
- ASR, second=0x80000000, top=4, reset_n pulsed low at cycle 2 → out_valid=0, carry=0, state IDLE. Instruction 0xFF → illegal pulses once, no out_valid.

Source files
------------

// File: rtl/alu_exec.sv
// alu_exec: registered valid/ready ALU execute stage with carry flag.
// Define ALU_EXEC_BARREL_SHIFT_EN for single-cycle barrel shifts.
`ifndef I_ADDZ
`define I_ADDZ   8'b0000_00??
`endif
`ifndef I_INC
`define I_INC    8'h10
`endif
`ifndef I_DEC
`define I_DEC    8'h11
`endif
`ifndef I_CARRY
`define I_CARRY  8'h12
`endif
`ifndef I_BORROW
`define I_BORROW 8'h13
`endif
`ifndef I_ADD
`define I_ADD    8'h14
`endif
`ifndef I_ADDC
`define I_ADDC   8'h15
`endif
`ifndef I_SUB
`define I_SUB    8'h16
`endif
`ifndef I_SUBC
`define I_SUBC   8'h17
`endif
`ifndef I_AND
`define I_AND    8'h20
`endif
`ifndef I_OR
`define I_OR     8'h21
`endif
`ifndef I_LSL
`define I_LSL    8'h30
`endif
`ifndef I_LSR
`define I_LSR    8'h31
`endif
`ifndef I_CSL
`define I_CSL    8'h32
`endif
`ifndef I_CSR
`define I_CSR    8'h33
`endif
`ifndef I_ASR
`define I_ASR    8'h34
`endif

module alu_exec #(
    parameter int WORD_WIDTH = 32,
    parameter int DC_COUNT   = 4,
    parameter int SHIFT_STEP = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [7:0]                     instruction,
    input  logic [WORD_WIDTH-1:0]          top,
    input  logic [WORD_WIDTH-1:0]          second,
    input  logic [DC_COUNT*WORD_WIDTH-1:0] dc_vals,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WORD_WIDTH-1:0]          result,
    output logic                           carry,
    output logic                           illegal
);
    localparam int SW = $clog2(WORD_WIDTH);
    localparam int IW = (DC_COUNT > 1) ? $clog2(DC_COUNT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_AND, OP_OR, OP_LSL, OP_LSR,
        OP_CSL, OP_CSR, OP_ASR, OP_ILL
    } op_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] result_q, result_d;
    logic                  carry_q, carry_d;
    logic                  out_valid_q, out_valid_d;
    logic                  illegal_q, illegal_d;

    op_t                   op;
    logic [WORD_WIDTH-1:0] add_a;
    logic                  add_ic;
    logic [WORD_WIDTH:0]   sum;
    logic [IW-1:0]         dc_idx;
    logic [SW-1:0]         shamt;
    logic                  accept;
    logic                  go_shift;

    function automatic logic [WORD_WIDTH-1:0] shift_by(
        input op_t                   o,
        input logic [WORD_WIDTH-1:0] d,
        input logic [SW-1:0]         a
    );
        logic [WORD_WIDTH-1:0] r;
        unique case (o)
            OP_LSL:  r = d << a;
            OP_LSR:  r = d >> a;
            OP_CSL:  r = (d << a) | (d >> (WORD_WIDTH - int'(a)));
            OP_CSR:  r = (d >> a) | (d << (WORD_WIDTH - int'(a)));
            OP_ASR:  r = $unsigned($signed(d) >>> a);
            default: r = d;
        endcase
        return r;
    endfunction

    assign dc_idx   = (DC_COUNT > 1) ? instruction[IW-1:0] : '0;
    assign shamt    = top[SW-1:0];
    assign in_ready = reset_n && (state_q != S_SHIFT) &&
                      (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign sum      = {1'b0, add_a} + {1'b0, top} +
                      {{WORD_WIDTH{1'b0}}, add_ic};

    always_comb begin
        op     = OP_ADD;
        add_a  = '0;
        add_ic = 1'b0;
        casez (instruction)
            `I_ADDZ:   add_a = dc_vals[int'(dc_idx)*WORD_WIDTH +: WORD_WIDTH];
            `I_INC:    add_a = WORD_WIDTH'(1);
            `I_DEC:    add_a = '1;
            `I_CARRY:  add_ic = carry_q;
            `I_BORROW: begin add_a = '1;      add_ic = carry_q; end
            `I_ADD:    add_a = second;
            `I_ADDC:   begin add_a = second;  add_ic = carry_q; end
            `I_SUB:    begin add_a = ~second; add_ic = 1'b1;    end
            `I_SUBC:   begin add_a = ~second; add_ic = carry_q; end
            `I_AND:    op = OP_AND;
            `I_OR:     op = OP_OR;
            `I_LSL:    op = OP_LSL;
            `I_LSR:    op = OP_LSR;
            `I_CSL:    op = OP_CSL;
            `I_CSR:    op = OP_CSR;
            `I_ASR:    op = OP_ASR;
            default:   op = OP_ILL;
        endcase
    end

`ifndef ALU_EXEC_BARREL_SHIFT_EN
    localparam logic [SW:0] STEP_W = SHIFT_STEP[SW:0];

    logic [WORD_WIDTH-1:0] sh_data_q, sh_data_d, sh_next;
    logic [SW-1:0]         sh_rem_q, sh_rem_d, step;
    op_t                   sh_op_q, sh_op_d;
    logic                  sh_last;

    // The last step consumes whatever remains, possibly less than SHIFT_STEP.
    assign sh_last = ({1'b0, sh_rem_q} <= STEP_W);
    assign step    = sh_last ? sh_rem_q : STEP_W[SW-1:0];
    assign sh_next = shift_by(sh_op_q, sh_data_q, step);
`endif

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q && !out_ready;
        illegal_d   = 1'b0;
        go_shift    = 1'b0;
`ifndef ALU_EXEC_BARREL_SHIFT_EN
        sh_data_d   = sh_data_q;
        sh_rem_d    = sh_rem_q;
        sh_op_d     = sh_op_q;
        if (state_q == S_SHIFT) begin
            sh_data_d = sh_next;
            sh_rem_d  = sh_rem_q - step;
            if (sh_last) begin
                result_d    = sh_next;
                out_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
        end else
`endif
        begin
            if (accept) begin
                unique case (op)
                    OP_ADD: begin
                        result_d    = sum[WORD_WIDTH-1:0];
                        carry_d     = sum[WORD_WIDTH];
                        out_valid_d = 1'b1;
                    end
                    OP_AND: begin
                        result_d    = second & top;
                        out_valid_d = 1'b1;
                    end
                    OP_OR: begin
                        result_d    = second | top;
                        out_valid_d = 1'b1;
                    end
                    OP_ILL: illegal_d = 1'b1;
                    default: begin
`ifdef ALU_EXEC_BARREL_SHIFT_EN
                        result_d    = shift_by(op, second, shamt);
                        out_valid_d = 1'b1;
`else
                        if (shamt == '0) begin
                            result_d    = second;
                            out_valid_d = 1'b1;
                        end else begin
                            go_shift  = 1'b1;
                            sh_data_d = second;
                            sh_rem_d  = shamt;
                            sh_op_d   = op;
                        end
`endif
                    end
                endcase
            end
            state_d = go_shift    ? S_SHIFT :
                      out_valid_d ? S_HOLD  : S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
`ifndef ALU_EXEC_BARREL_SHIFT_EN
            sh_data_q   <= '0;
            sh_rem_q    <= '0;
            sh_op_q     <= OP_LSL;
`endif
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
`ifndef ALU_EXEC_BARREL_SHIFT_EN
            sh_data_q   <= sh_data_d;
            sh_rem_q    <= sh_rem_d;
            sh_op_q     <= sh_op_d;
`endif
        end
    end

    assign result    = result_q;
    assign carry     = carry_q;
    assign out_valid = out_valid_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: vector table, hand-written handshake/reset sequences and
// randomized ops checked against a behavioural model of the stage.
module tb_alu_exec;
    localparam int W    = 32;
    localparam int DC   = 4;
    localparam int STEP = 1;

    localparam logic [7:0] C_INC = 8'h10, C_DEC = 8'h11, C_CARRY = 8'h12;
    localparam logic [7:0] C_BORROW = 8'h13, C_ADD = 8'h14, C_ADDC = 8'h15;
    localparam logic [7:0] C_SUB = 8'h16, C_SUBC = 8'h17;
    localparam logic [7:0] C_AND = 8'h20, C_OR = 8'h21;
    localparam logic [7:0] C_LSL = 8'h30, C_LSR = 8'h31, C_CSL = 8'h32;
    localparam logic [7:0] C_CSR = 8'h33, C_ASR = 8'h34;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [7:0]      instruction = 8'h00;
    logic [W-1:0]    top = '0;
    logic [W-1:0]    second = '0;
    logic [DC*W-1:0] dc_vals = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-1:0]    result;
    logic            carry;
    logic            illegal;

    int           total = 0;
    int           bad = 0;
    logic         mc;
    logic [W-1:0] mr;

    typedef struct {
        logic [7:0]   ins;
        logic [W-1:0] t;
        logic [W-1:0] s;
        logic [W-1:0] r;
        logic         c;
    } vec_t;

    alu_exec #(.WORD_WIDTH(W), .DC_COUNT(DC), .SHIFT_STEP(STEP)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .top(top), .second(second),
        .dc_vals(dc_vals),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic void model(
        input  logic [7:0] ins, input logic [W-1:0] t, input logic [W-1:0] s,
        input  logic cin, input logic [W-1:0] rin,
        output logic ill, output logic [W-1:0] r, output logic c,
        output int lat
    );
        longint unsigned a, sum, mx;
        logic [W-1:0] d;
        int n, ic;
        logic is_add;
        mx = 64'hFFFF_FFFF;
        ill = 1'b0; r = rin; c = cin; lat = 1;
        a = 0; ic = 0; is_add = 1'b1;
        n = int'(t % W);
        d = s;
        case (ins)
            8'h00, 8'h01, 8'h02, 8'h03: a = dc_vals[ins[1:0]*W +: W];
            C_INC:    a = 1;
            C_DEC:    a = mx;
            C_CARRY:  ic = int'(cin);
            C_BORROW: begin a = mx; ic = int'(cin); end
            C_ADD:    a = s;
            C_ADDC:   begin a = s; ic = int'(cin); end
            C_SUB:    begin a = mx - s; ic = 1; end
            C_SUBC:   begin a = mx - s; ic = int'(cin); end
            C_AND:    begin is_add = 1'b0; r = s & t; end
            C_OR:     begin is_add = 1'b0; r = s | t; end
            C_LSL, C_LSR, C_CSL, C_CSR, C_ASR: begin
                is_add = 1'b0;
                for (int i = 0; i < n; i++) begin
                    case (ins)
                        C_LSL: d = W'(d * 2);
                        C_LSR: d = d / 2;
                        C_CSL: d = {d[W-2:0], d[W-1]};
                        C_CSR: d = {d[0], d[W-1:1]};
                        default: d = (d / 2) | (d & 32'h8000_0000);
                    endcase
                end
                r = d;
`ifndef ALU_EXEC_BARREL_SHIFT_EN
                if (n > 0) lat = 1 + (n + STEP - 1) / STEP;
`endif
            end
            default: begin is_add = 1'b0; ill = 1'b1; end
        endcase
        if (is_add) begin
            sum = a + t + longint'(ic);
            r = sum[W-1:0];
            c = sum > mx;
        end
    endfunction

    task automatic do_op(input logic [7:0] ins, input logic [W-1:0] t,
                         input logic [W-1:0] s, input string nm);
        logic ill, ec;
        logic [W-1:0] er;
        int elat, lat, w;
        model(ins, t, s, mc, mr, ill, er, ec, elat);
        @(negedge clk);
        instruction = ins; top = t; second = s;
        in_valid = 1'b1; out_ready = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk({nm, "/in_ready"}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (ill) begin
            chk({nm, "/illegal"}, illegal, 1);
            chk({nm, "/ill_valid"}, out_valid, 0);
            chk({nm, "/ill_result"}, result, mr);
            chk({nm, "/ill_carry"}, carry, mc);
            @(posedge clk);
            #1 chk({nm, "/ill_pulse_end"}, illegal, 0);
        end else begin
            lat = 1;
            while (!out_valid && lat < 200) begin
                @(posedge clk);
                #1 lat++;
            end
            chk({nm, "/latency"}, lat, elat);
            chk({nm, "/result"}, result, er);
            chk({nm, "/carry"}, carry, ec);
            mr = er;
            mc = ec;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[20];
        logic [7:0] ops[$];
        logic [7:0] ins;
        logic [W-1:0] t;
        int cnt;

        dc_vals = {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
        mc = 1'b0;
        mr = '0;
        out_ready = 1'b1;
        #12;
        chk("reset/out_valid", out_valid, 0);
        chk("reset/carry", carry, 0);
        chk("reset/illegal", illegal, 0);
        chk("reset/result", result, 0);
        chk("reset/in_ready", in_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;

        tbl[0]  = '{C_ADD,    32'd5,         32'd7,         32'd12,        1'b0};
        tbl[1]  = '{C_ADD,    32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1};
        tbl[2]  = '{C_ADDC,   32'd0,         32'd0,         32'd1,         1'b0};
        tbl[3]  = '{C_SUB,    32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0};
        tbl[4]  = '{C_SUB,    32'd5,         32'd3,         32'd2,         1'b1};
        tbl[5]  = '{C_CARRY,  32'd10,        32'd0,         32'd11,        1'b0};
        tbl[6]  = '{C_BORROW, 32'd0,         32'd0,         32'hFFFF_FFFF, 1'b0};
        tbl[7]  = '{C_INC,    32'hFFFF_FFFF, 32'd0,         32'd0,         1'b1};
        tbl[8]  = '{C_SUBC,   32'd5,         32'd3,         32'd2,         1'b1};
        tbl[9]  = '{C_DEC,    32'd0,         32'd0,         32'hFFFF_FFFF, 1'b0};
        tbl[10] = '{C_AND,    32'hFF00,      32'hF0F0,      32'hF000,      1'b0};
        tbl[11] = '{C_OR,     32'hFF00,      32'hF0F0,      32'hFFF0,      1'b0};
        tbl[12] = '{C_LSL,    32'd5,         32'd1,         32'h20,        1'b0};
        tbl[13] = '{C_LSR,    32'd31,        32'h8000_0000, 32'd1,         1'b0};
        tbl[14] = '{C_CSL,    32'd1,         32'h8000_0001, 32'd3,         1'b0};
        tbl[15] = '{C_CSR,    32'd4,         32'd1,         32'h1000_0000, 1'b0};
        tbl[16] = '{C_ASR,    32'd4,         32'h8000_0000, 32'hF800_0000, 1'b0};
        tbl[17] = '{C_LSL,    32'd64,        32'h1234,      32'h1234,      1'b0};
        tbl[18] = '{8'h02,    32'd5,         32'd0,         32'h3000_0005, 1'b0};
        tbl[19] = '{8'h03,    32'hC000_0000, 32'd0,         32'd0,         1'b1};
        for (int i = 0; i < 20; i++) begin
            do_op(tbl[i].ins, tbl[i].t, tbl[i].s, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d/tbl_result", i), result, tbl[i].r);
            chk($sformatf("vec%0d/tbl_carry", i), carry, tbl[i].c);
        end

        // LSL by 5: in_ready stays low while the shift iterates.
        @(negedge clk);
        instruction = C_LSL; top = 32'd5; second = 32'd1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_valid) break;
            if (!in_ready) cnt++;
        end
`ifdef ALU_EXEC_BARREL_SHIFT_EN
        chk("lsl5/ready_low_cycles", cnt, 0);
`else
        chk("lsl5/ready_low_cycles", cnt, 5);
`endif
        chk("lsl5/result", result, 32'h20);
        mr = 32'h20;

        // Backpressure: result held, then released with a same-cycle accept.
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        instruction = C_ADD; top = 32'd5; second = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 top = 32'd1; second = 32'd2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d/out_valid", k), out_valid, 1);
            chk($sformatf("hold%0d/result", k), result, 32'd12);
            chk($sformatf("hold%0d/in_ready", k), in_ready, 0);
        end
        out_ready = 1'b1;
        #1 chk("release/in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("release/out_valid", out_valid, 1);
        chk("release/result", result, 32'd3);
        chk("release/carry", carry, 0);
        mr = 32'd3;
        mc = 1'b0;

        // Reset in the middle of an ASR.
        do_op(C_ADD, 32'hFFFF_FFFF, 32'd1, "pre_rst");
        @(negedge clk);
        instruction = C_ASR; top = 32'd4; second = 32'h8000_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_mid/out_valid", out_valid, 0);
        chk("rst_mid/carry", carry, 0);
        chk("rst_mid/result", result, 0);
        chk("rst_mid/in_ready", in_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("rst_mid/idle_ready", in_ready, 1);
        repeat (8) @(posedge clk);
        #1 chk("rst_mid/discarded", out_valid, 0);
        mc = 1'b0;
        mr = '0;

        do_op(C_ADD, 32'd1, 32'd1, "pre_ill");
        do_op(8'hFF, 32'd9, 32'd9, "ill_ff");

        ops = '{8'h00, 8'h01, 8'h02, 8'h03, C_INC, C_DEC, C_CARRY, C_BORROW,
                C_ADD, C_ADDC, C_SUB, C_SUBC, C_AND, C_OR, C_LSL, C_LSR,
                C_CSL, C_CSR, C_ASR, 8'hFF, 8'h40, 8'h22, 8'h35};
        for (int i = 0; i < DC; i++) dc_vals[i*W +: W] = $urandom;
        for (int i = 0; i < 300; i++) begin
            ins = ops[$urandom_range(0, ops.size() - 1)];
            t = $urandom;
            if ($urandom_range(0, 3) == 0) t = W'($urandom_range(0, 3));
            do_op(ins, t, $urandom, $sformatf("rnd%0d_%0h", i, ins));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
